// File: rtl/relu_backward_ctrl.sv
// Sequencer for the ReLU backward datapath: reads one vector at a time, waits out the
// datapath latency and writes the result back, with one vector in flight.
module relu_backward_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DP_LATENCY = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [ADDR_W-1:0]         base_in_addr_i,
    input  logic [ADDR_W-1:0]         base_out_addr_i,
    input  logic [ADDR_W-1:0]         num_vecs_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_W-1:0]         vec_count_o,
    output logic                      rd_req_o,
    output logic [ADDR_W-1:0]         rd_addr_o,
    input  logic                      rd_valid_i,
    input  logic [WIDTH*DATA_W-1:0]   rd_data_i,
    output logic [WIDTH*DATA_W-1:0]   dp_in_vec_o,
    input  logic [WIDTH*DATA_W-1:0]   dp_out_vec_i,
    output logic                      wr_req_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [WIDTH*DATA_W-1:0]   wr_data_o,
    input  logic                      wr_ready_i
);

    localparam int VEC_W = WIDTH * DATA_W;
    localparam int LAT_W = 4;

    typedef enum logic [2:0] {IDLE, RD, RWAIT, EXEC, WR, FIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_in_q, base_out_q, num_q, vec_count_q;
    logic [LAT_W-1:0]    lat_q;
    logic [VEC_W-1:0]    dp_in_q, wr_data_q;

    logic                start_ok, rd_accept, exec_last, wr_fire, last_vec;

    // The vector index k always equals the number of vectors written in this job.
    assign last_vec  = (vec_count_q + ADDR_W'(1)) == num_q;
    assign start_ok  = (state_q == IDLE) && start_i && !abort_i;
    assign rd_accept = (state_q == RWAIT) && rd_valid_i && !abort_i;
    assign exec_last = (state_q == EXEC) && (lat_q <= LAT_W'(1)) && !abort_i;
    assign wr_fire   = (state_q == WR) && wr_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = (num_vecs_i == '0) ? FIN : RD;
            RD:      state_d = RWAIT;
            RWAIT:   if (rd_valid_i) state_d = EXEC;
            EXEC:    if (lat_q <= LAT_W'(1)) state_d = WR;
            WR:      if (wr_ready_i) state_d = last_vec ? FIN : RD;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == FIN);
        rd_req_o    = (state_q == RD);
        wr_req_o    = (state_q == WR);
        vec_count_o = vec_count_q;
        rd_addr_o   = base_in_q + vec_count_q;
        wr_addr_o   = base_out_q + vec_count_q;
        dp_in_vec_o = dp_in_q;
        wr_data_o   = wr_data_q;
    end

    // A write accepted in the same cycle as abort still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_in_q   <= '0;
            base_out_q  <= '0;
            num_q       <= '0;
            vec_count_q <= '0;
            lat_q       <= '0;
            dp_in_q     <= '0;
            wr_data_q   <= '0;
        end else begin
            if (start_ok) begin
                base_in_q   <= base_in_addr_i;
                base_out_q  <= base_out_addr_i;
                num_q       <= num_vecs_i;
                vec_count_q <= '0;
            end else if (wr_fire) begin
                vec_count_q <= vec_count_q + ADDR_W'(1);
            end
            if (rd_accept) begin
                dp_in_q <= rd_data_i;
                lat_q   <= LAT_W'(DP_LATENCY);
            end else if (state_q == EXEC) begin
                lat_q <= lat_q - LAT_W'(1);
            end
            if (exec_last) begin
                wr_data_q <= dp_out_vec_i;
            end
        end
    end

endmodule

// File: tb/tb_relu_backward_ctrl.sv
// Bench for relu_backward_ctrl: a buffer/datapath responder plus a job-level reference
// model (expected addresses, golden data, done latency) checked after every job.
module tb_relu_backward_ctrl;

    localparam int W  = 8;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int L  = 1;
    localparam int VW = W * DW;

    typedef struct {
        int          n;
        logic [15:0] baseIn;
        logic [15:0] baseOut;
        int          rdLat;
        int          stallVec;
        int          stallLen;
        int          expDone;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, rdValid, wrReady;
    logic [AW-1:0] baseIn, baseOut, numVecs;
    logic          busy, done, rdReq, wrReq;
    logic [AW-1:0] vecCount, rdAddr, wrAddr;
    logic [VW-1:0] rdData, dpIn, dpOut, wrData;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int rdLat = 1, rdCountdown = 0;
    int stallVec = -1, stallLen = 0, stallCnt = 0, wrIdx = 0;
    int busyCycles = 0;
    logic [AW-1:0] snapAddr;
    logic [VW-1:0] snapData;
    logic [AW-1:0] rdAddrQ[$], wrAddrQ[$];
    logic [VW-1:0] rdDataQ[$], wrDataQ[$];
    int            rdCycQ[$], doneCycQ[$];

    relu_backward_ctrl #(.WIDTH(W), .DATA_W(DW), .ADDR_W(AW), .DP_LATENCY(L)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .base_in_addr_i(baseIn), .base_out_addr_i(baseOut), .num_vecs_i(numVecs),
        .busy_o(busy), .done_o(done), .vec_count_o(vecCount),
        .rd_req_o(rdReq), .rd_addr_o(rdAddr), .rd_valid_i(rdValid), .rd_data_i(rdData),
        .dp_in_vec_o(dpIn), .dp_out_vec_i(dpOut),
        .wr_req_o(wrReq), .wr_addr_o(wrAddr), .wr_data_o(wrData), .wr_ready_i(wrReady)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the single-cycle datapath: keep elements with sign 0 and non-zero magnitude.
    always_comb begin
        dpOut = '0;
        for (int i = 0; i < W; i++) begin
            if (!dpIn[i*DW+31] && (dpIn[i*DW +: 31] != '0)) dpOut[i*DW +: DW] = dpIn[i*DW +: DW];
        end
    end

    function automatic logic [VW-1:0] goldenVec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        int signed     e;
        r = '0;
        for (int i = 0; i < W; i++) begin
            e = $signed(v[i*DW +: DW]);
            if (e > 0) r[i*DW +: DW] = v[i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] randElem();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] r;
        for (int i = 0; i < W; i++) r[i*DW +: DW] = randElem();
        return r;
    endfunction

    function automatic int modelDone(input job_t j);
        return j.n * (L + 2 + j.rdLat) + ((j.stallVec >= 0 && j.stallVec < j.n) ? j.stallLen : 0) + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read/write buffer responder and event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            rdValid     = 1'b0;
            rdCountdown = 0;
        end else begin
            rdValid = 1'b0;
            if (busy) busyCycles++;
            if (done) doneCycQ.push_back(cyc);
            if (rdCountdown > 0) begin
                rdCountdown--;
                if (rdCountdown == 0) begin
                    rdData  = randVec();
                    rdValid = 1'b1;
                    rdDataQ.push_back(rdData);
                end
            end
            if (rdReq) begin
                rdAddrQ.push_back(rdAddr);
                rdCycQ.push_back(cyc);
                rdCountdown = rdLat;
            end
            if (wrReq && wrIdx == stallVec && stallCnt < stallLen) begin
                wrReady = 1'b0;
                if (stallCnt == 0) begin
                    snapAddr = wrAddr;
                    snapData = wrData;
                end else begin
                    checkOutput("stallWrReq", VW'(wrReq), VW'(1));
                    checkOutput("stallWrAddr", VW'(wrAddr), VW'(snapAddr));
                    checkOutput("stallWrData", wrData, snapData);
                end
                stallCnt++;
            end else begin
                wrReady = 1'b1;
                if (wrReq) begin
                    if (stallCnt > 0) begin
                        checkOutput("stallWrAddrEnd", VW'(wrAddr), VW'(snapAddr));
                        checkOutput("stallWrDataEnd", wrData, snapData);
                    end
                    wrAddrQ.push_back(wrAddr);
                    wrDataQ.push_back(wrData);
                    wrIdx++;
                    stallCnt = 0;
                end
            end
        end
    end

    task automatic clearLogs();
        rdAddrQ.delete(); wrAddrQ.delete(); rdDataQ.delete(); wrDataQ.delete();
        rdCycQ.delete(); doneCycQ.delete();
        busyCycles = 0; wrIdx = 0; stallCnt = 0;
    endtask

    task automatic startJob(input job_t j, output int startCyc);
        rdLat = j.rdLat; stallVec = j.stallVec; stallLen = j.stallLen;
        clearLogs();
        @(negedge clk);
        start = 1'b1; numVecs = 16'(j.n); baseIn = j.baseIn; baseOut = j.baseOut;
        startCyc = cyc;
        @(negedge clk);
        start = 1'b0; numVecs = 16'($urandom); baseIn = 16'($urandom); baseOut = 16'($urandom);
    endtask

    task automatic applyStimulus(input job_t j, input string tag);
        int startCyc;
        int m;
        startJob(j, startCyc);
        for (int i = 0; i < 500 && doneCycQ.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
        checkOutput({tag, ".doneCount"}, VW'(doneCycQ.size()), VW'(1));
        if (doneCycQ.size() > 0) checkOutput({tag, ".doneLatency"}, VW'(doneCycQ[0] - startCyc), VW'(j.expDone));
        checkOutput({tag, ".busyCycles"}, VW'(busyCycles), VW'(j.expDone));
        checkOutput({tag, ".rdCount"}, VW'(rdAddrQ.size()), VW'(j.n));
        checkOutput({tag, ".wrCount"}, VW'(wrAddrQ.size()), VW'(j.n));
        if (j.n > 0 && rdCycQ.size() > 0) checkOutput({tag, ".firstRdCycle"}, VW'(rdCycQ[0] - startCyc), VW'(1));
        m = (rdAddrQ.size() < j.n) ? rdAddrQ.size() : j.n;
        for (int k = 0; k < m; k++) checkOutput({tag, ".rdAddr"}, VW'(rdAddrQ[k]), VW'(16'(j.baseIn + 16'(k))));
        m = (wrAddrQ.size() < j.n) ? wrAddrQ.size() : j.n;
        if (rdDataQ.size() < m) m = rdDataQ.size();
        for (int k = 0; k < m; k++) begin
            checkOutput({tag, ".wrAddr"}, VW'(wrAddrQ[k]), VW'(16'(j.baseOut + 16'(k))));
            checkOutput({tag, ".wrData"}, wrDataQ[k], goldenVec(rdDataQ[k]));
        end
        checkOutput({tag, ".vecCount"}, VW'(vecCount), VW'(j.n));
        checkOutput({tag, ".busyIdle"}, VW'(busy), VW'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, VW'(busy), VW'(0));
        checkOutput({tag, ".done"}, VW'(done), VW'(0));
        checkOutput({tag, ".rdReq"}, VW'(rdReq), VW'(0));
        checkOutput({tag, ".wrReq"}, VW'(wrReq), VW'(0));
        checkOutput({tag, ".rdAddr"}, VW'(rdAddr), VW'(0));
        checkOutput({tag, ".wrAddr"}, VW'(wrAddr), VW'(0));
        checkOutput({tag, ".vecCount"}, VW'(vecCount), VW'(0));
        checkOutput({tag, ".dpIn"}, dpIn, VW'(0));
        checkOutput({tag, ".wrData"}, wrData, VW'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        job_t jobTable[6];
        job_t j;
        int   startCyc;

        jobTable[0] = '{3, 16'h0010, 16'h0080, 1, -1, 0, 13};
        jobTable[1] = '{0, 16'h0020, 16'h0030, 1, -1, 0, 1};
        jobTable[2] = '{3, 16'h0040, 16'h0090, 1, 1, 5, 18};
        jobTable[3] = '{3, 16'hFFFE, 16'h0100, 1, -1, 0, 13};
        jobTable[4] = '{1, 16'h0005, 16'hFFFF, 3, -1, 0, 7};
        jobTable[5] = '{2, 16'h0000, 16'h0000, 2, 0, 2, 13};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wrReady = 1'b1; rdValid = 1'b0;
        baseIn = '0; baseOut = '0; numVecs = '0; rdData = '0;
        repeat (2) @(negedge clk);
        #1 checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) applyStimulus(jobTable[t], $sformatf("table%0d", t));

        for (int t = 0; t < 12; t++) begin
            j.n        = $urandom_range(1, 6);
            j.baseIn   = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
            j.baseOut  = 16'($urandom);
            j.rdLat    = $urandom_range(1, 4);
            j.stallVec = $urandom_range(0, j.n);
            j.stallLen = $urandom_range(1, 4);
            j.expDone  = modelDone(j);
            applyStimulus(j, $sformatf("rand%0d", t));
        end

        // Abort while waiting for the second vector's read data; the late data must not land.
        j = '{3, 16'h0200, 16'h0300, 4, -1, 0, 0};
        startJob(j, startCyc);
        for (int i = 0; i < 200 && rdAddrQ.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("abort.doneCount", VW'(doneCycQ.size()), VW'(0));
        checkOutput("abort.busy", VW'(busy), VW'(0));
        checkOutput("abort.vecCount", VW'(vecCount), VW'(1));
        checkOutput("abort.rdCount", VW'(rdAddrQ.size()), VW'(2));
        checkOutput("abort.wrCount", VW'(wrAddrQ.size()), VW'(1));
        checkOutput("abort.lateDataSeen", VW'(rdDataQ.size()), VW'(2));
        if (rdDataQ.size() > 0) checkOutput("abort.dpInHeld", dpIn, rdDataQ[0]);

        // Start together with abort in IDLE must not start a job.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; numVecs = 16'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        checkOutput("startAbort.busy", VW'(busy), VW'(0));
        checkOutput("startAbort.rdReq", VW'(rdReq), VW'(0));
        checkOutput("startAbort.vecCount", VW'(vecCount), VW'(1));

        // Reset pulled during EXEC of the first vector, then a fresh job.
        j = '{3, 16'h0400, 16'h0500, 1, -1, 0, 0};
        startJob(j, startCyc);
        for (int i = 0; i < 200 && rdDataQ.size() < 1; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkAllZero("midReset");
        @(negedge clk);
        #1 checkAllZero("midResetHeld");
        rst_n = 1'b1;
        applyStimulus('{2, 16'h0600, 16'h0700, 1, -1, 0, 9}, "afterReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
